// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand/opcode request side and result/status response side.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             err;

  modport slave (
    input  in_valid, opcode, in1, in2, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err
  );

  modport master (
    output in_valid, opcode, in1, in2, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative shift-add multiply and
// restoring divide/remainder sharing one hi/lo accumulator pair.
module alu_seq #(
  parameter int WIDTH         = 32,
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ONE, S_BUSY, S_DONE} state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             z_q, n_q, c_q, v_q, err_q, out_valid_q;

  logic signed [WIDTH-1:0] a_s;
  logic [WIDTH-1:0]        res_d;
  logic [WIDTH:0]          ext_d;
  logic                    c_d, v_d, err_d;

  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge, accept_muldiv;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c, fin_err;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  always_comb begin
    a_s   = $signed(a_q);
    res_d = '0;
    ext_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    err_d = 1'b0;
    case (op_q)
      4'h1: begin
        ext_d = {1'b0, a_q} + {1'b0, b_q};
        res_d = ext_d[WIDTH-1:0];
        c_d   = ext_d[WIDTH];
        v_d   = add_ovf(a_q[WIDTH-1], b_q[WIDTH-1], ext_d[WIDTH-1]);
      end
      4'h2: begin
        ext_d = {1'b0, a_q} - {1'b0, b_q};
        res_d = ext_d[WIDTH-1:0];
        c_d   = ext_d[WIDTH];
        v_d   = sub_ovf(a_q[WIDTH-1], b_q[WIDTH-1], ext_d[WIDTH-1]);
      end
      // Shifts by the full in2 value: oversize amounts flush to 0 / sign bits.
      4'h3:    res_d = a_q << b_q;
      4'h4:    res_d = a_q >> b_q;
      4'h5:    res_d = a_s >>> b_q;
      4'h6:    res_d = a_q & b_q;
      4'h7:    res_d = a_q | b_q;
      4'h8:    res_d = a_q ^ b_q;
      4'h9:    res_d = ~a_q;
      default: err_d = 1'b1;
    endcase
  end

  // Multiply: hi accumulates, lo shifts out multiplier bits and in product bits.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in;
  // the borrow bit of the trial subtraction decides each quotient bit.
  assign mul_sum  = {1'b0, hi_q} + {1'b0, {WIDTH{lo_q[0]}} & a_q};
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_ge   = ~div_diff[WIDTH];

  assign fin_res = (op_q == 4'hC) ? hi_q : lo_q;
  assign fin_c   = (op_q == 4'hA) && (|hi_q);
  assign fin_err = (op_q != 4'hA) && (b_q == '0);

  assign accept_muldiv = ENABLE_MULDIV && (bus.opcode >= 4'hA) && (bus.opcode <= 4'hC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q    <= bus.opcode;
            a_q     <= bus.in1;
            b_q     <= bus.in2;
            hi_q    <= '0;
            lo_q    <= (bus.opcode == 4'hA) ? bus.in2 : bus.in1;
            cnt_q   <= '0;
            state_q <= accept_muldiv ? S_BUSY : S_ONE;
          end
        end
        S_ONE: begin
          result_q    <= res_d;
          z_q         <= (res_d == '0);
          n_q         <= res_d[WIDTH-1];
          c_q         <= c_d;
          v_q         <= v_d;
          err_q       <= err_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_BUSY: begin
          if (cnt_q == CNT_W'(WIDTH)) begin
            result_q    <= fin_res;
            z_q         <= (fin_res == '0);
            n_q         <= fin_res[WIDTH-1];
            c_q         <= fin_c;
            v_q         <= 1'b0;
            err_q       <= fin_err;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (op_q == 4'hA) begin
              {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
            end else begin
              hi_q <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
              lo_q <= {lo_q[WIDTH-2:0], div_ge};
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;
  assign bus.err       = err_q;
endmodule
